gpio_seq_wb8: RTL
=================

# gpio_seq_wb8

Autonomous pattern sequencer for the 8-bit Wishbone GPIO peripheral. The CPU loads a short table of output patterns, a dwell period and a pin-direction mask through a Wishbone slave port. On start, the block acts as the Wishbone master on the GPIO peripheral's port. It writes the direction register, then steps through the pattern table, writing each entry to the GPIO value register and holding it for the dwell period. It runs once or loops, and frees the CPU from bit-banging timed output sequences.

## Interface
- DEPTH, 8: pattern table entries; power of two, 2..16.
- PERIOD_W, 16: dwell counter width; fixed at 16 by the register map.
- I_wb_clk  in  1  clock.
- I_reset  in  1  reset; synchronous, active-high.
- I_wb_adr  in  3  slave register address.
- I_wb_dat  in  8  slave write data.
- I_wb_stb  in  1  slave strobe.
- I_wb_we  in  1  slave write enable.
- O_wb_ack  out  1  slave acknowledge.
- O_wb_dat  out  8  slave read data.
- O_m_adr  out  2  master address to GPIO (0 = value, 1 = direction).
- O_m_dat  out  8  master write data.
- O_m_stb  out  1  master strobe.
- O_m_we  out  1  master write enable; constant 1.
- I_m_ack  in  1  master acknowledge from GPIO.
- O_busy  out  1  sequencer not IDLE.
- O_irq  out  1  completion pulse; present only with GPIO_SEQ_IRQ_EN.

## Operation
- Slave accept: access accepted when I_wb_stb && !O_wb_ack. O_wb_ack pulses for exactly one cycle, the cycle after accept. O_wb_dat is registered at accept. A strobe held through ack yields exactly one side effect.
- Register map:
  - 0 CTRL. Write: bit0 START, bit1 LOOP, bit2 STOP, bit3 IRQEN. Read: bit0 busy, bit1 LOOP, bit2 DONE (sticky), bit3 IRQEN.
  - 1 LEN: steps 0..DEPTH; values above DEPTH saturate to DEPTH.
  - 2 PERIOD_LO, 3 PERIOD_HI: 16-bit dwell.
  - 4 DIR: direction mask.
  - 5 IDX: table pointer, log2(DEPTH) bits.
  - 6 DATA: write stores table[IDX] then IDX <= IDX+1 mod DEPTH; read returns table[IDX] with no increment.
  - 7 STEP: current step, read-only.
- START write clears DONE. START and STOP in the same write: STOP wins. START while busy is ignored. LEN and DIR writes while busy are ignored. PERIOD, LOOP, IDX and DATA writes while busy are accepted and take effect at the next use.
- FSM states: IDLE, WR_DIR, WR_PAT, DWELL, WAIT_ABORT.
  - IDLE + START: if LEN=0, set DONE and stay IDLE. Otherwise step <= 0 and go to WR_DIR.
  - WR_DIR: drive adr=1, dat=DIR, stb=1 until I_m_ack, then go to WR_PAT.
  - WR_PAT: drive adr=0, dat=table[step] until I_m_ack, then go to DWELL with counter <= max(PERIOD,1).
  - DWELL: decrement each cycle. At 1:
    - if step != LEN-1: step++ and go to WR_PAT;
    - else if LOOP: step <= 0 and go to WR_PAT;
    - else set DONE and go to IDLE.
  - STOP in IDLE or DWELL: go to IDLE; DONE unchanged.
  - STOP in WR_DIR or WR_PAT: go to WAIT_ABORT, which keeps stb asserted until I_m_ack, then goes to IDLE. An outstanding master cycle is never abandoned.
- GPIO pins retain the last written value after completion or STOP.

## Timing
- Reset values:
  - O_wb_ack=0, O_wb_dat=0, O_m_stb=0, O_m_adr=0, O_m_dat=0, O_m_we=1, O_busy=0, O_irq=0.
  - Registers LEN=0, PERIOD=0, DIR=0, IDX=0, STEP=0, CTRL bits all 0.
  - Table contents are not reset.
- Reset mid-transaction drops O_m_stb in the next cycle; this is the only exception to the never-abandon rule.
- START accepted at edge T: O_busy=1 and O_m_stb=1 (DIR write) from T+1.
- Master stb deasserts the cycle after I_m_ack is sampled high. The next stb starts no earlier than one cycle later, so stb always has at least one low cycle between transactions.
- Step period, measured from pattern ack to next pattern stb: PERIOD+1 cycles. PERIOD=0 behaves as PERIOD=1.
- Completion: DONE and O_busy=0 are visible the cycle after the final dwell expires.
- All outputs are registered; no combinational path from I_m_ack to O_m_stb.

## Configuration
- GPIO_SEQ_IRQ_EN defined:
  - O_irq pulses high for one cycle when DONE is set by natural completion (including LEN=0 start), only if IRQEN=1.
  - STOP never raises O_irq.
- Not defined: O_irq port absent, CTRL bit3 reads 0, writes to it are ignored.

## Test plan
- Reset: every output at its reset value; CTRL reads 0x00; STEP reads 0.
- Load table 0x01,0x02,0x04 via IDX=0 and DATA×3, then LEN=3, PERIOD=4, DIR=0xFF, START. Required response:
  - master writes in order: adr1/0xFF, then adr0/0x01, 0x02, 0x04;
  - 5 cycles from each pattern ack to the next stb;
  - DONE=1 and busy=0 after the final dwell.
- LOOP=1, LEN=2: pattern sequence repeats 0x01,0x02,0x01,…. STOP during WR_PAT with the GPIO ack stalled 3 cycles: stb is held until ack, then IDLE, no further writes, DONE=0.
- LEN=0, START: no master activity; DONE=1 the next cycle; O_irq pulses once with the macro and IRQEN=1.
- Slave stb held 4 cycles on a DATA write: exactly one table write, IDX increments by exactly 1. START+STOP in the same write: no activity.
- I_reset asserted mid-DWELL: O_m_stb=0, O_busy=0 next cycle; table contents preserved and read back unchanged.

Source files
------------

// File: rtl/gpio_seq_wb8.sv
`default_nettype none
// ============================================================================
// Module   : gpio_seq_wb8
// Purpose  : Autonomous output-pattern sequencer for the 8-bit Wishbone GPIO
//            peripheral. A CPU loads a pattern table, dwell period and pin
//            direction mask through a Wishbone slave port. On START the block
//            becomes the Wishbone master on the GPIO port. It writes the
//            direction register, then walks the table, writing each entry to
//            the GPIO value register and holding it for the dwell period.
//            It runs once or loops.
// Ports    : I_wb_clk, I_reset (synchronous, active-high)
//            I_wb_adr/I_wb_dat/I_wb_stb/I_wb_we -> O_wb_ack/O_wb_dat  (slave)
//            O_m_adr/O_m_dat/O_m_stb/O_m_we <- I_m_ack           (master)
//            O_busy : sequencer not idle
//            O_irq  : completion pulse (only when GPIO_SEQ_IRQ_EN is defined)
// Options  : GPIO_SEQ_IRQ_EN -- adds O_irq and the CTRL IRQEN bit.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_seq_wb8 #(
    parameter int DEPTH    = 8,   // table entries, power of two, 2..16
    parameter int PERIOD_W = 16   // dwell counter width (register map fixes 16)
) (
    input  logic       I_wb_clk,
    input  logic       I_reset,
    input  logic [2:0] I_wb_adr,
    input  logic [7:0] I_wb_dat,
    input  logic       I_wb_stb,
    input  logic       I_wb_we,
    output logic       O_wb_ack,
    output logic [7:0] O_wb_dat,
    output logic [1:0] O_m_adr,
    output logic [7:0] O_m_dat,
    output logic       O_m_stb,
    output logic       O_m_we,
    input  logic       I_m_ack,
    output logic       O_busy
`ifdef GPIO_SEQ_IRQ_EN
    ,
    output logic       O_irq
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = IDX_W + 1;    // LEN ranges 0..DEPTH inclusive

    // Slave register map
    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_LEN  = 3'd1;
    localparam logic [2:0] A_PLO  = 3'd2;
    localparam logic [2:0] A_PHI  = 3'd3;
    localparam logic [2:0] A_DIR  = 3'd4;
    localparam logic [2:0] A_IDX  = 3'd5;
    localparam logic [2:0] A_DATA = 3'd6;
    localparam logic [2:0] A_STEP = 3'd7;

    // Master addresses on the GPIO peripheral
    localparam logic [1:0] M_VALUE = 2'd0;
    localparam logic [1:0] M_DIR   = 2'd1;

    // Sequencer states
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_DIR     = 3'd1;
    localparam logic [2:0] S_WR_PAT     = 3'd2;
    localparam logic [2:0] S_DWELL      = 3'd3;
    localparam logic [2:0] S_WAIT_ABORT = 3'd4;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]          table_mem [DEPTH];
    logic [LEN_W-1:0]    len;
    logic [PERIOD_W-1:0] period;
    logic [7:0]          dir;
    logic [IDX_W-1:0]    idx;
    logic                loop_en;
    logic                done;
    logic                irqen_rd;

    // Sequencer state
    logic [2:0]          state,  state_nxt;
    logic [IDX_W-1:0]    step,   step_nxt;
    logic [PERIOD_W-1:0] count,  count_nxt;
    logic                done_set;   // natural completion this cycle

    // Registered-output next values
    logic                stb_nxt;
    logic [1:0]          adr_nxt;
    logic [7:0]          dat_nxt;
    logic                busy_nxt;

    // ------------------------------------------------------------------
    // Slave access decode
    // ------------------------------------------------------------------
    // hold remembers that the current strobe has already been served, so a
    // master that keeps stb high across the ack gets one side effect only;
    // a new access needs stb to drop first.
    logic       hold;
    logic       acc;
    logic       wr;
    logic       ctrl_wr;
    logic       start_req;
    logic       stop_req;
    logic       start_ok;
    logic       m_xfer;
    logic       last_step;
    logic [7:0] rd_data;

    assign acc       = I_wb_stb && !O_wb_ack && !hold;
    assign wr        = acc && I_wb_we;
    assign ctrl_wr   = wr && (I_wb_adr == A_CTRL);
    assign stop_req  = ctrl_wr && I_wb_dat[2];
    // STOP wins over START in the same write.
    assign start_req = ctrl_wr && I_wb_dat[0] && !I_wb_dat[2];
    assign start_ok  = start_req && (state == S_IDLE);
    // A master cycle completes only while our strobe is actually up.
    assign m_xfer    = O_m_stb && I_m_ack;
    assign last_step = (LEN_W'(step) == (len - LEN_W'(1)));
    assign O_m_we    = 1'b1;

    // ------------------------------------------------------------------
    // Slave read mux (captured into O_wb_dat at accept)
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        case (I_wb_adr)
            A_CTRL: rd_data = {4'b0000, irqen_rd, done, loop_en, O_busy};
            A_LEN:  rd_data = {{(8 - LEN_W){1'b0}}, len};
            A_PLO:  rd_data = period[7:0];
            A_PHI:  rd_data = period[PERIOD_W-1:8];
            A_DIR:  rd_data = dir;
            A_IDX:  rd_data = {{(8 - IDX_W){1'b0}}, idx};
            A_DATA: rd_data = table_mem[idx];
            A_STEP: rd_data = {{(8 - IDX_W){1'b0}}, step};
            default: rd_data = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Slave registers
    // ------------------------------------------------------------------
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            O_wb_ack <= 1'b0;
            O_wb_dat <= 8'h00;
            hold     <= 1'b0;
            len      <= '0;
            period   <= '0;
            dir      <= 8'h00;
            idx      <= '0;
            loop_en  <= 1'b0;
        end else begin
            O_wb_ack <= acc;
            hold     <= I_wb_stb && (hold || acc);
            if (acc) begin
                O_wb_dat <= rd_data;
            end
            if (wr) begin
                case (I_wb_adr)
                    A_CTRL: loop_en <= I_wb_dat[1];
                    A_LEN: begin
                        // Length and direction are frozen while a run is active.
                        if (!O_busy) begin
                            if (I_wb_dat > 8'(DEPTH)) begin
                                len <= LEN_W'(DEPTH);
                            end else begin
                                len <= I_wb_dat[LEN_W-1:0];
                            end
                        end
                    end
                    A_PLO:  period[7:0]          <= I_wb_dat;
                    A_PHI:  period[PERIOD_W-1:8] <= I_wb_dat;
                    A_DIR:  if (!O_busy) dir <= I_wb_dat;
                    A_IDX:  idx <= I_wb_dat[IDX_W-1:0];
                    A_DATA: idx <= idx + IDX_W'(1);   // wraps mod DEPTH
                    default: ;
                endcase
            end
        end
    end

    // Table contents survive reset; only the pointer is cleared.
    always_ff @(posedge I_wb_clk) begin
        if (!I_reset && wr && (I_wb_adr == A_DATA)) begin
            table_mem[idx] <= I_wb_dat;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: state register (also registers every master output)
    // ------------------------------------------------------------------
    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            state   <= S_IDLE;
            step    <= '0;
            count   <= '0;
            done    <= 1'b0;
            O_m_stb <= 1'b0;
            O_m_adr <= 2'd0;
            O_m_dat <= 8'h00;
            O_busy  <= 1'b0;
        end else begin
            state   <= state_nxt;
            step    <= step_nxt;
            count   <= count_nxt;
            O_m_stb <= stb_nxt;
            O_m_adr <= adr_nxt;
            O_m_dat <= dat_nxt;
            O_busy  <= busy_nxt;
            if (done_set) begin
                done <= 1'b1;
            end else if (start_ok) begin
                done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        count_nxt = count;
        done_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    if (len == '0) begin
                        done_set = 1'b1;
                    end else begin
                        step_nxt  = '0;
                        state_nxt = S_WR_DIR;
                    end
                end
            end
            S_WR_DIR, S_WR_PAT: begin
                if (m_xfer) begin
                    // The cycle just finished, so a STOP now has nothing
                    // outstanding to wait for.
                    if (stop_req) begin
                        state_nxt = S_IDLE;
                    end else if (state == S_WR_DIR) begin
                        state_nxt = S_WR_PAT;
                    end else begin
                        state_nxt = S_DWELL;
                        count_nxt = (period == '0) ? PERIOD_W'(1) : period;
                    end
                end else if (stop_req) begin
                    // Strobe low means we are in the inter-cycle gap with
                    // nothing on the bus; otherwise finish the open cycle.
                    state_nxt = O_m_stb ? S_WAIT_ABORT : S_IDLE;
                end
            end
            S_DWELL: begin
                if (stop_req) begin
                    state_nxt = S_IDLE;
                end else if (count <= PERIOD_W'(1)) begin
                    if (!last_step) begin
                        step_nxt  = step + IDX_W'(1);
                        state_nxt = S_WR_PAT;
                    end else if (loop_en) begin
                        step_nxt  = '0;
                        state_nxt = S_WR_PAT;
                    end else begin
                        done_set  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    count_nxt = count - PERIOD_W'(1);
                end
            end
            S_WAIT_ABORT: begin
                if (m_xfer) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer: output logic (values registered by the state register)
    // ------------------------------------------------------------------
    // Strobe drops on the edge that samples the ack and can only rise again
    // one cycle later, which guarantees a low cycle between transactions.
    // Address/data are only reloaded while the strobe is low so they stay
    // stable for the whole of an open cycle.
    always_comb begin
        stb_nxt  = 1'b0;
        adr_nxt  = O_m_adr;
        dat_nxt  = O_m_dat;
        busy_nxt = (state_nxt != S_IDLE);
        case (state_nxt)
            S_WR_DIR: begin
                stb_nxt = !m_xfer;
                if (!O_m_stb) begin
                    adr_nxt = M_DIR;
                    dat_nxt = dir;
                end
            end
            S_WR_PAT: begin
                stb_nxt = !m_xfer;
                if (!O_m_stb) begin
                    adr_nxt = M_VALUE;
                    dat_nxt = table_mem[step_nxt];
                end
            end
            S_WAIT_ABORT: stb_nxt = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Completion interrupt
    // ------------------------------------------------------------------
`ifdef GPIO_SEQ_IRQ_EN
    logic irqen;
    logic irqen_eff;

    // A START that also sets IRQEN (e.g. LEN=0 immediate completion) must
    // see the new enable in the same cycle.
    assign irqen_eff = ctrl_wr ? I_wb_dat[3] : irqen;
    assign irqen_rd  = irqen;

    always_ff @(posedge I_wb_clk) begin
        if (I_reset) begin
            irqen <= 1'b0;
            O_irq <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irqen <= I_wb_dat[3];
            end
            O_irq <= done_set && irqen_eff;
        end
    end
`else
    assign irqen_rd = 1'b0;
`endif

endmodule
`default_nettype wire
